fetch_unit: RTL and testbench

Parametrised instruction fetch front-end for the ARM32 core: owns the program counter, issues word reads to the synchronous instruction RAM, buffers returned words with their PCs in a prefetch queue, and presents them to decode over a valid/ready handshake. It supports branch redirects with queue flush and in-flight squash, fetch stalling, and an optional alignment fault. It sits between the `ram` instance and decode inside `processor`, replacing the direct `mem[pc]` read.

---
 rtl/arm_pkg.sv | 13 +
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit_queue.sv | 63 ++++++
 rtl/fetch_unit.sv | 106 ++++++++++
 tb/tb_fetch_unit.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arm_pkg.sv
// Shared ARM32 core types and defaults used by the fetch front-end.
package arm_pkg;

  localparam int unsigned ARCH_DEFAULT = 32;
  localparam int unsigned WORD_BYTES   = 4;
  localparam logic [ARCH_DEFAULT-1:0] RESET_PC_DEFAULT = '0;

  typedef struct packed {
    logic [ARCH_DEFAULT-1:0] ins;
    logic [ARCH_DEFAULT-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction RAM read port plus decode-side valid/ready channel of the fetch unit.
interface fetch_unit_if
  import arm_pkg::*;
#(
  parameter int unsigned ARCH = ARCH_DEFAULT,
  parameter int unsigned AW   = 12
);

  logic            mem_rd_en;
  logic [AW-1:0]   mem_addr;
  logic [ARCH-1:0] mem_rdata;
  logic            out_valid;
  logic            out_ready;
  logic [ARCH-1:0] out_ins;
  logic [ARCH-1:0] out_pc;

  modport master (
    output mem_rd_en, mem_addr, out_valid, out_ins, out_pc,
    input  mem_rdata, out_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, out_valid, out_ins, out_pc,
    output mem_rdata, out_ready
  );

endinterface

// File: rtl/fetch_unit_queue.sv
// Prefetch FIFO of fetch_entry_t with flush and a registered head entry.
module fetch_queue
  import arm_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  din,
  input  logic          pop,
  output logic [CW-1:0] count,
  output fetch_entry_t  head
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_next;
  logic          pop_eff;
  logic [CW-1:0] count_after_pop;

  always_comb begin
    pop_eff         = pop && (count != '0);
    rd_next         = rd_ptr + PW'(pop_eff);
    count_after_pop = count - CW'(pop_eff);
  end

  always_ff @(posedge clk) begin
    if (push && !flush && !reset) begin
      mem[wr_ptr] <= din;
    end
  end

  // head mirrors mem[rd_ptr]; a push into an empty (or emptying) queue bypasses straight into it
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_next;
      count  <= count_after_pop + CW'(push);
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (push && (count_after_pop == '0)) begin
        head <= din;
      end else if (pop_eff) begin
        head <= mem[rd_next];
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: PC, RAM read issue, in-flight squash and prefetch queue.
// Define FETCH_ALIGN_CHECK_EN to add the sticky misaligned-redirect fault output.
module fetch_unit
  import arm_pkg::*;
#(
  parameter int unsigned     ARCH        = ARCH_DEFAULT,
  parameter int unsigned     RAM_SIZE    = 4096,
  parameter int unsigned     QUEUE_DEPTH = 4,
  parameter logic [ARCH-1:0] RESET_PC    = ARCH'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_en,
  input  logic            redirect_valid,
  input  logic [ARCH-1:0] redirect_pc,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic            fault,
`endif
  fetch_unit_if.master    bus
);

  localparam int unsigned AW = $clog2(RAM_SIZE);
  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;

  logic [ARCH-1:0] pc;
  logic [ARCH-1:0] rsp_pc;
  logic [ARCH-1:0] target;
  logic            inflight;
  logic            kill;
  logic            issue;
  logic            push;
  logic            pop;
  logic            blocked;
  logic [CW-1:0]   count;
  logic [CW:0]     occupancy;
  fetch_entry_t    wr_entry;
  fetch_entry_t    head;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      fault_q <= 1'b1;
    end
  end

  assign fault   = fault_q;
  assign blocked = fault_q;
  assign target  = redirect_pc;
`else
  assign blocked = 1'b0;
  assign target  = redirect_pc & ~ARCH'(WORD_BYTES - 1);
`endif

  // credit for the in-flight read is reserved at issue, so the queue cannot overflow
  always_comb begin
    occupancy      = {1'b0, count} + (CW + 1)'(inflight);
    issue          = fetch_en && !redirect_valid && !reset && !blocked
                     && (occupancy < (CW + 1)'(QUEUE_DEPTH));
    push           = inflight && !kill && !redirect_valid;
    pop            = bus.out_valid && bus.out_ready && !redirect_valid;
    wr_entry.ins   = bus.mem_rdata;
    wr_entry.pc    = rsp_pc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      rsp_pc   <= '0;
      inflight <= 1'b0;
      kill     <= 1'b0;
    end else begin
      inflight <= issue;
      kill     <= redirect_valid && inflight;
      if (redirect_valid) begin
        pc <= target;
      end else if (issue) begin
        pc     <= pc + ARCH'(WORD_BYTES);
        rsp_pc <= pc;
      end
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (push),
    .din   (wr_entry),
    .pop   (pop),
    .count (count),
    .head  (head)
  );

  assign bus.mem_rd_en = issue;
  assign bus.mem_addr  = pc[AW+1:2];
  assign bus.out_valid = (count != '0);
  assign bus.out_ins   = head.ins;
  assign bus.out_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized and directed bench for fetch_unit with a sequential-PC scoreboard.
module tb_fetch_unit;

  localparam int unsigned ARCH     = 32;
  localparam int unsigned RAM_SIZE = 4096;
  localparam int unsigned QD       = 4;
  localparam int unsigned AW       = $clog2(RAM_SIZE);

  logic            clk            = 1'b0;
  logic            reset          = 1'b1;
  logic            fetch_en       = 1'b0;
  logic            redirect_valid = 1'b0;
  logic [ARCH-1:0] redirect_pc    = '0;
`ifdef FETCH_ALIGN_CHECK_EN
  logic            fault;
`endif

  fetch_unit_if #(.ARCH(ARCH), .AW(AW)) bus ();

  fetch_unit #(
    .ARCH        (ARCH),
    .RAM_SIZE    (RAM_SIZE),
    .QUEUE_DEPTH (QD),
    .RESET_PC    (32'h0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
`ifdef FETCH_ALIGN_CHECK_EN
    .fault          (fault),
`endif
    .bus            (bus.master)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [RAM_SIZE];

  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rdata <= ram[bus.mem_addr];
  end

  int          total    = 0;
  int          bad      = 0;
  int          accepted = 0;
  logic [31:0] exp_q [$];
  bit          fault_model = 1'b0;
  bit          hold_prev   = 1'b0;
  logic [31:0] prev_pc     = '0;
  logic [31:0] prev_ins    = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ram_word(input logic [31:0] pc);
    return ram[(pc >> 2) % RAM_SIZE];
  endfunction

  function automatic logic [31:0] model_target(input logic [31:0] t);
`ifdef FETCH_ALIGN_CHECK_EN
    return t;
`else
    return t & 32'hFFFF_FFFC;
`endif
  endfunction

  // Expected output stream: consecutive word PCs from the last restart point.
  task automatic model_restart(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    if (reset) begin
      model_restart(32'h0);
      hold_prev   = 1'b0;
      fault_model = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_pc", bus.out_pc, prev_pc);
        check("hold_ins", bus.out_ins, prev_ins);
      end
      if (!fetch_en || redirect_valid || fault_model)
        check("no_issue", 32'(bus.mem_rd_en), 32'd0);
      if (redirect_valid) begin
`ifdef FETCH_ALIGN_CHECK_EN
        if (redirect_pc[1:0] != 2'b00) fault_model = 1'b1;
`endif
        model_restart(model_target(redirect_pc));
        hold_prev = 1'b0;
      end else begin
        if (bus.out_valid && bus.out_ready) begin
          e = exp_q[0];
          exp_q.push_back(exp_q[$] + 32'd4);
          void'(exp_q.pop_front());
          check("out_pc", bus.out_pc, e);
          check("out_ins", bus.out_ins, ram_word(e));
          accepted++;
        end
        hold_prev = bus.out_valid && !bus.out_ready;
        prev_pc   = bus.out_pc;
        prev_ins  = bus.out_ins;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_to(input logic [31:0] t);
    redirect_valid = 1'b1;
    redirect_pc    = t;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_accepted(input int goal, input int budget, input string name);
    int n;
    n = 0;
    while (accepted < goal && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(accepted >= goal), 32'd1);
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(bus.out_valid), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, iss, vld, rd, acc0, found;
    logic [31:0] tgt;

    for (int i = 0; i < int'(RAM_SIZE); i++) ram[i] = $urandom;
    ram[0] = 32'hE3A00001;
    ram[1] = 32'hE3A01002;
    ram[2] = 32'hE0802001;
    ram[3] = 32'hEAFFFFFE;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_ins", bus.out_ins, 32'd0);
    check("rst_pc", bus.out_pc, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
    check("rst_fault", 32'(fault), 32'd0);
`endif

    // reset release: latency and gap-free first four words
    step();
    reset = 1'b0; fetch_en = 1'b1; bus.out_ready = 1'b1;
    n = 0; iss = -1; vld = -1;
    while (vld < 0 && n < 10) begin
      @(negedge clk);
      if (bus.mem_rd_en && iss < 0) iss = n;
      if (bus.out_valid) vld = n;
      n++;
    end
    check("fetch_latency", 32'(vld - iss), 32'd2);
    check("first_pc", bus.out_pc, 32'h0);
    check("first_ins", bus.out_ins, 32'hE3A00001);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check("nogap_valid", 32'(bus.out_valid), 32'd1);
      check("nogap_pc", bus.out_pc, 32'(4 * i));
    end

    // back-pressure from a clean restart at 0
    step();
    bus.out_ready = 1'b0;
    redirect_to(32'h0);
    rd = 0;
    repeat (10) begin
      @(negedge clk);
      rd += int'(bus.mem_rd_en);
    end
    check("bp_reads", 32'(rd), 32'(QD));
    check("bp_valid", 32'(bus.out_valid), 32'd1);
    check("bp_pc", bus.out_pc, 32'h0);
    step();
    bus.out_ready = 1'b1;
    acc0 = accepted;
    wait_accepted(acc0 + 5, 30, "bp_drain");

    // redirect while the read of 0x8 is in flight
    step();
    redirect_to(32'h0);
    found = 0; n = 0;
    while (found == 0 && n < 20) begin
      @(negedge clk);
      if (bus.mem_rd_en && bus.mem_addr == AW'(2)) found = 1;
      n++;
    end
    check("find_rd8", 32'(found), 32'd1);
    step();
    redirect_to(32'h40);
    @(negedge clk);
    check("rdr_valid_low", 32'(bus.out_valid), 32'd0);
    check("rdr_rd_en", 32'(bus.mem_rd_en), 32'd1);
    check("rdr_addr", 32'(bus.mem_addr), 32'h10);
    wait_valid(10, "rdr_target_valid");
    check("rdr_target_pc", bus.out_pc, 32'h40);

    // stall: queue drains, fetch continues sequentially afterwards
    step();
    repeat (4) step();
    fetch_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 4) check("stall_drained", 32'(bus.out_valid), 32'd0);
      step();
    end
    fetch_en = 1'b1;
    acc0 = accepted;
    wait_accepted(acc0 + 4, 20, "stall_resume");

    // RAM address wrap
    step();
    redirect_to(32'h3FFC);
    @(negedge clk);
    check("wrap_rd_hi", 32'(bus.mem_rd_en), 32'd1);
    check("wrap_addr_hi", 32'(bus.mem_addr), 32'(RAM_SIZE - 1));
    step();
    @(negedge clk);
    check("wrap_rd_lo", 32'(bus.mem_rd_en), 32'd1);
    check("wrap_addr_lo", 32'(bus.mem_addr), 32'd0);
    acc0 = accepted;
    wait_accepted(acc0 + 3, 20, "wrap_stream");

    // misaligned redirect
    step();
    redirect_to(32'h42);
    @(negedge clk);
`ifdef FETCH_ALIGN_CHECK_EN
    check("fault_set", 32'(fault), 32'd1);
    check("fault_no_issue", 32'(bus.mem_rd_en), 32'd0);
    repeat (8) @(negedge clk);
    check("fault_empty", 32'(bus.out_valid), 32'd0);
    check("fault_sticky", 32'(fault), 32'd1);
    step();
    reset = 1'b1;
    step();
    step();
    @(negedge clk);
    check("fault_cleared", 32'(fault), 32'd0);
    step();
    reset = 1'b0;
`else
    wait_valid(10, "align_valid");
    check("align_pc", bus.out_pc, 32'h40);
`endif

    // randomized traffic
    step();
    acc0 = accepted;
    for (int i = 0; i < 400; i++) begin
      fetch_en       = ($urandom_range(3) != 0);
      bus.out_ready  = ($urandom_range(9) < 6);
      redirect_valid = ($urandom_range(19) == 0);
      reset          = ($urandom_range(199) == 0);
      tgt            = 32'($urandom_range(RAM_SIZE - 1)) << 2;
`ifndef FETCH_ALIGN_CHECK_EN
      tgt            = tgt | 32'($urandom_range(3));
`endif
      redirect_pc    = tgt;
      step();
    end
    reset = 1'b0; redirect_valid = 1'b0; fetch_en = 1'b1; bus.out_ready = 1'b1;
    repeat (10) step();
    check("random_progress", 32'(accepted > acc0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
